conv_frame_sequencer: RTL

Hardware frame sequencer for the 5x5 convolution filter core (`test_top`). It streams one full frame from a word-addressed pixel memory into the core, replacing testbench-driven stimulus:
- 25 kernel coefficients in kernel mode;
- six priming lines;
- one line per core interrupt;
- two zero padding lines.

It counts the core's output beats and pulses done after the last output pixel.

---
 rtl/conv_frame_sequencer_if.sv | 34 +++
 rtl/conv_frame_sequencer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/conv_frame_sequencer_if.sv
// Bus bundle between the frame sequencer, its pixel memory and the filter core.
// The master side is the sequencer; the slave side is memory, core and host.
interface conv_frame_sequencer_if #(
    parameter int ADDR_W = 19
);
    logic              i_start;
    logic [ADDR_W-1:0] i_kernel_base;
    logic [ADDR_W-1:0] i_image_base;
    logic              o_mem_rd;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [7:0]        i_mem_rdata;
    logic              o_data_valid;
    logic [7:0]        o_data;
    logic              o_kernel_mode;
    logic              i_intr;
    logic              i_out_valid;
    logic              o_busy;
    logic              o_done;
    logic              o_overrun;

    modport master (
        input  i_start, i_kernel_base, i_image_base, i_mem_rdata,
        input  i_intr, i_out_valid,
        output o_mem_rd, o_mem_addr, o_data_valid, o_data,
        output o_kernel_mode, o_busy, o_done, o_overrun
    );

    modport slave (
        output i_start, i_kernel_base, i_image_base, i_mem_rdata,
        output i_intr, i_out_valid,
        input  o_mem_rd, o_mem_addr, o_data_valid, o_data,
        input  o_kernel_mode, o_busy, o_done, o_overrun
    );
endinterface

// File: rtl/conv_frame_sequencer.sv
// Streams kernel, priming lines, interrupt-paced lines and zero padding
// from pixel memory into the 5x5 filter core; counts output pixels.
module conv_frame_sequencer #(
    parameter int IMG_WIDTH   = 512,
    parameter int IMG_HEIGHT  = 512,
    parameter int KERNEL_TAPS = 25,
    parameter int PRIME_LINES = 6,
    parameter int PAD_LINES   = 2,
    parameter int ADDR_W      = 19
) (
    input  logic axi_clk,
    input  logic axi_reset_n,
    conv_frame_sequencer_if.master bus
);
    localparam int PIX    = IMG_WIDTH * IMG_HEIGHT;
    localparam int OCW    = $clog2(PIX + 1);
    localparam int PBEATS = PRIME_LINES * IMG_WIDTH;
    localparam int PHMAX  = (PBEATS > KERNEL_TAPS) ? PBEATS : KERNEL_TAPS;
    localparam int PHW    = $clog2(PHMAX + 1);
    localparam int BODY   = IMG_HEIGHT - PRIME_LINES;
    localparam int TOTAL  = BODY + PAD_LINES;
    localparam int LCW    = $clog2(TOTAL + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_KERNEL, S_GAP, S_PRIME,
        S_WAIT, S_LINE, S_PAD, S_DRAIN
    } state_t;

    state_t            state, state_d;
    logic [PHW-1:0]    phase_cnt, limit;
    logic [LCW-1:0]    line_cnt;
    logic [ADDR_W-1:0] img_ptr, kbase;
    logic [OCW-1:0]    out_cnt;
    logic              pending, armed, overrun;
    logic              beat_vld, beat_rd, beat_kmode;
    logic              rd, pad, kread, consume, done;
    logic              start_ok, armed_c;

    assign start_ok = (state == S_IDLE) && bus.i_start;
    // Interrupts count from the first PRIME cycle until the frame ends.
    assign armed_c  = armed || (state == S_PRIME);

    always_comb begin
        state_d = state;
        limit   = '0;
        rd      = 1'b0;
        pad     = 1'b0;
        kread   = 1'b0;
        consume = 1'b0;
        done    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (bus.i_start) state_d = S_KERNEL;
            end
            S_KERNEL: begin
                limit = PHW'(KERNEL_TAPS);
                if (phase_cnt == limit) begin
                    state_d = S_GAP;
                end else begin
                    rd    = 1'b1;
                    kread = 1'b1;
                end
            end
            S_PRIME: begin
                limit = PHW'(PBEATS);
                if (phase_cnt == limit) state_d = S_GAP;
                else rd = 1'b1;
            end
            S_LINE: begin
                limit = PHW'(IMG_WIDTH);
                if (phase_cnt == limit) state_d = S_GAP;
                else rd = 1'b1;
            end
            S_PAD: begin
                limit = PHW'(IMG_WIDTH);
                if (phase_cnt == limit) state_d = S_GAP;
                else pad = 1'b1;
            end
            S_GAP: begin
                if (!armed) state_d = S_PRIME;
                else if (line_cnt == LCW'(TOTAL)) state_d = S_DRAIN;
                else state_d = S_WAIT;
            end
            S_WAIT: begin
                if (pending) begin
                    consume = 1'b1;
                    state_d = (line_cnt < LCW'(BODY)) ? S_LINE : S_PAD;
                end
            end
            S_DRAIN: begin
                if (out_cnt == OCW'(PIX)) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            state      <= S_IDLE;
            phase_cnt  <= '0;
            line_cnt   <= '0;
            img_ptr    <= '0;
            kbase      <= '0;
            out_cnt    <= '0;
            pending    <= 1'b0;
            armed      <= 1'b0;
            overrun    <= 1'b0;
            beat_vld   <= 1'b0;
            beat_rd    <= 1'b0;
            beat_kmode <= 1'b0;
        end else begin
            state      <= state_d;
            beat_vld   <= rd || pad;
            beat_rd    <= rd;
            beat_kmode <= kread;

            if (state_d != state) phase_cnt <= '0;
            else if (rd || pad) phase_cnt <= phase_cnt + PHW'(1);

            if (rd && !kread) img_ptr <= img_ptr + ADDR_W'(1);

            if ((state == S_LINE || state == S_PAD) && state_d == S_GAP)
                line_cnt <= line_cnt + LCW'(1);

            if (state == S_PRIME) armed <= 1'b1;
            else if (done) armed <= 1'b0;

            // A single credit: a same-cycle consume leaves the new one set.
            if (armed_c && bus.i_intr) begin
                pending <= 1'b1;
                if (pending && !consume) overrun <= 1'b1;
            end else if (consume) begin
                pending <= 1'b0;
            end

            if (state != S_IDLE && bus.i_out_valid && out_cnt != OCW'(PIX))
                out_cnt <= out_cnt + OCW'(1);

            if (start_ok) begin
                kbase    <= bus.i_kernel_base;
                img_ptr  <= bus.i_image_base;
                out_cnt  <= '0;
                pending  <= 1'b0;
                overrun  <= 1'b0;
                armed    <= 1'b0;
                line_cnt <= '0;
            end
        end
    end

    assign bus.o_mem_rd      = rd;
    assign bus.o_mem_addr    = !rd   ? '0 :
                               kread ? kbase + ADDR_W'(phase_cnt) : img_ptr;
    assign bus.o_data_valid  = beat_vld;
    assign bus.o_data        = beat_rd ? bus.i_mem_rdata : 8'd0;
    assign bus.o_kernel_mode = beat_kmode;
    assign bus.o_busy        = (state != S_IDLE);
    assign bus.o_done        = done;
    assign bus.o_overrun     = overrun;
endmodule
